// File: rtl/wb_master_bridge.sv
// ----------------------------------------------------------------------------
// wb_master_bridge
//
// Wishbone classic single-transfer initiator. Each command accepted on the
// valid/ready command stream becomes exactly one Wishbone cycle. The outcome
// (read data, slave error or bus-hang timeout) is returned on the valid/ready
// response stream. Only one transfer is outstanding at a time. Every output
// comes straight from a register.
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_we_i, cmd_adr_i,       command fields: write enable, address,
//   cmd_dat_i, cmd_sel_i       write data, byte enables
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_dat_o                  read data (0 for write, error or timeout)
//   rsp_err_o, rsp_timeout_o   slave error / transfer aborted by timeout
//   wbm_*                      Wishbone master-side signals
//   busy_o                     high whenever the bridge is not idle
// ----------------------------------------------------------------------------
module wb_master_bridge #(
    parameter int unsigned  ADDR_W         = 32,
    parameter int unsigned  DATA_W         = 32,
    parameter int unsigned  TIMEOUT_W      = 16,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    localparam int unsigned SEL_W          = DATA_W / 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    // command stream
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,
    // response stream
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    // Wishbone master side
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic              wbm_stb_o,
    output logic              wbm_cyc_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    // status
    output logic              busy_o
);

    // A zero TIMEOUT_CYCLES disables the timeout entirely.
    localparam logic                 TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_W < 32) begin : g_to_chk
        if (TIMEOUT_CYCLES >= (32'd1 << TIMEOUT_W)) begin : g_to_bad
            $error("TIMEOUT_CYCLES must be below 2**TIMEOUT_W");
        end
    end

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e               r_state;
    logic                 r_cmd_ready;
    logic                 r_busy;
    logic                 r_cyc;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_adr;
    logic [DATA_W-1:0]    r_dat;
    logic [SEL_W-1:0]     r_sel;
    logic [TIMEOUT_W-1:0] r_count;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_dat;
    logic                 r_rsp_err;
    logic                 r_rsp_timeout;

    logic w_accept;
    logic w_to_hit;

    // r_cmd_ready is only ever set while idle, so it alone qualifies acceptance.
    assign w_accept = r_cmd_ready & cmd_valid_i;
    assign w_to_hit = TO_EN && (r_count == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state       <= StIdle;
            r_cmd_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
            r_count       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    // Ready rises on the first edge after reset release.
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_we        <= cmd_we_i;
                        r_adr       <= cmd_adr_i;
                        r_dat       <= cmd_dat_i;
                        r_sel       <= cmd_sel_i;
                        r_count     <= '0;
                        r_cyc       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= StBus;
                    end
                end

                StBus: begin
                    // Saturate so a huge TIMEOUT_W never wraps into a false hit.
                    if (r_count != '1) begin
                        r_count <= r_count + TIMEOUT_W'(1);
                    end
                    // Priority: err > ack > timeout.
                    if (wbm_err_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_state     <= StResp;
                    end else if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
                        r_state     <= StResp;
                    end else if (w_to_hit) begin
                        r_cyc         <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_dat     <= '0;
                        r_state       <= StResp;
                    end
                end

                StResp: begin
                    // Late ack/err from the slave are deliberately ignored here.
                    if (rsp_ready_i) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_dat     <= '0;
                        r_busy        <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= StIdle;
                    end
                end

                default: begin
                    r_cyc       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign busy_o        = r_busy;
    assign wbm_cyc_o     = r_cyc;
    assign wbm_stb_o     = r_cyc;
    assign wbm_we_o      = r_we;
    assign wbm_adr_o     = r_adr;
    assign wbm_dat_o     = r_dat;
    assign wbm_sel_o     = r_sel;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_wb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_wb_master_bridge
//
// Directed bench for wb_master_bridge with an 8-cycle timeout. A behavioural
// slave answers Wishbone cycles; expected responses are queued when commands
// are issued and checked when the response handshake happens.
// ----------------------------------------------------------------------------
module tb_wb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_we;
    logic [SW-1:0] wbm_sel;
    logic          wbm_stb;
    logic          wbm_cyc;
    logic          wbm_ack;
    logic          wbm_err;
    logic          busy;

    wb_master_bridge #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_W     (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .cmd_sel_i    (cmd_sel),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_dat_o    (rsp_dat),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .wbm_adr_o    (wbm_adr),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_we_o     (wbm_we),
        .wbm_sel_o    (wbm_sel),
        .wbm_stb_o    (wbm_stb),
        .wbm_cyc_o    (wbm_cyc),
        .wbm_ack_i    (wbm_ack),
        .wbm_err_i    (wbm_err),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
        logic          to;
    } rsp_t;

    rsp_t exp_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   rsp_seen = 0;

    // slave configuration
    logic          slv_on     = 1'b1;
    logic          slv_fixed  = 1'b0;
    logic          slv_rand   = 1'b0;
    logic          slv_ack_en = 1'b1;
    logic          slv_err_en = 1'b0;
    int            slv_wait   = 0;
    int            cur_wait   = 0;
    logic          man_ack    = 1'b0;
    logic [DW-1:0] man_dat    = '0;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] adr);
        return adr ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural slave: acks after a programmable number of wait states.
    initial begin : slave
        int cnt;
        int wt;
        cnt       = 0;
        wbm_ack   = 1'b0;
        wbm_err   = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!slv_on) begin
                wbm_ack   = man_ack;
                wbm_err   = 1'b0;
                wbm_dat_i = man_dat;
                cnt       = 0;
            end else if (wbm_cyc && !wbm_ack && !wbm_err) begin
                wt = slv_rand ? cur_wait : slv_wait;
                if (cnt >= wt) begin
                    wbm_ack   = slv_ack_en;
                    wbm_err   = slv_err_en;
                    wbm_dat_i = slv_fixed ? 32'hDEAD_BEEF : model_rd(wbm_adr);
                end else begin
                    cnt++;
                end
            end else begin
                wbm_ack   = 1'b0;
                wbm_err   = 1'b0;
                wbm_dat_i = '0;
                cnt       = 0;
                cur_wait  = int'($urandom_range(0, 3));
            end
        end
    end

    // Response scoreboard and ready/busy exclusivity monitor.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            chk("ready_while_busy", 64'(cmd_ready & busy), 64'd0);
            if (rsp_valid && rsp_ready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL rsp_unexpected: observed dat %0h with empty queue, required none",
                           rsp_dat);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    rsp_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel, input rsp_t e);
        logic ok;
        ok        = 1'b0;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 64'(ok), 64'd1);
        if (ok) exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : main
        int          n;
        int          base;
        logic        ok;
        logic [AW-1:0] a;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_cyc", 64'(wbm_cyc), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Read, zero-wait slave
        slv_fixed = 1'b1;
        slv_wait  = 0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3080_0004;
        cmd_dat   = '0;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("rd_cyc", 64'(wbm_cyc), 64'd1);
        chk("rd_stb", 64'(wbm_stb), 64'd1);
        chk("rd_adr", 64'(wbm_adr), 64'h3080_0004);
        chk("rd_we", 64'(wbm_we), 64'd0);
        chk("rd_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("rd_cyc_one", 64'(wbm_cyc), 64'd0);
        chk("rd_rsp_valid_n2", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_dat", 64'(rsp_dat), 64'hDEAD_BEEF);
        @(posedge clk);
        #1;
        chk("rd_rsp_done", 64'(rsp_valid), 64'd0);
        chk("rd_ready_n3", 64'(cmd_ready), 64'd1);
        slv_fixed = 1'b0;

        // Write with 3 wait states and response backpressure
        rsp_ready = 1'b0;
        slv_wait  = 3;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3082_0008;
        cmd_dat   = 32'h0000_00A5;
        cmd_sel   = 4'b0001;
        cmd_valid = 1'b1;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_cyc", 64'(wbm_cyc), 64'd1);
            chk("wr_dat", 64'(wbm_dat_o), 64'h0000_00A5);
            chk("wr_sel", 64'(wbm_sel), 64'd1);
            chk("wr_we", 64'(wbm_we), 64'd1);
            chk("wr_adr", 64'(wbm_adr), 64'h3082_0008);
            @(posedge clk);
            #1;
        end
        chk("wr_cyc_end", 64'(wbm_cyc), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("wr_rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("wr_rsp_hold_dat", 64'(rsp_dat), 64'd0);
            chk("wr_rsp_hold_ready", 64'(cmd_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_rsp_done", 64'(rsp_valid), 64'd0);
        chk("wr_ready_back", 64'(cmd_ready), 64'd1);

        // Error together with ack: error wins, data forced to zero
        slv_wait   = 1;
        slv_err_en = 1'b1;
        send(1'b0, 32'h3081_0010, 32'h0, 4'hF, '{32'h0, 1'b1, 1'b0});
        drain();
        slv_err_en = 1'b0;

        // Timeout: no ack at all
        rsp_ready  = 1'b0;
        slv_ack_en = 1'b0;
        cmd_we     = 1'b0;
        cmd_adr    = 32'h3083_0000;
        cmd_valid  = 1'b1;
        exp_q.push_back('{32'h0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (wbm_cyc && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("to_cyc_cycles", 64'(n), 64'(TO));
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_flag", 64'(rsp_timeout), 64'd1);
        // Late ack during RESP and then IDLE must change nothing
        slv_on  = 1'b0;
        man_ack = 1'b1;
        man_dat = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("late_valid", 64'(rsp_valid), 64'd1);
            chk("late_to", 64'(rsp_timeout), 64'd1);
            chk("late_dat", 64'(rsp_dat), 64'd0);
            chk("late_err", 64'(rsp_err), 64'd0);
            chk("late_cyc", 64'(wbm_cyc), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("late_rsp_done", 64'(rsp_valid), 64'd0);
        chk("late_to_clr", 64'(rsp_timeout), 64'd0);
        @(posedge clk);
        #1;
        chk("late_idle_cyc", 64'(wbm_cyc), 64'd0);
        chk("late_idle_busy", 64'(busy), 64'd0);
        man_ack    = 1'b0;
        slv_on     = 1'b1;
        slv_ack_en = 1'b1;
        @(posedge clk);
        #1;

        // Ack in the final timeout cycle counts as success
        slv_wait = int'(TO) - 1;
        a        = 32'h3084_0004;
        send(1'b0, a, 32'h0, 4'hF, '{model_rd(a), 1'b0, 1'b0});
        drain();

        // Asynchronous reset in the middle of a bus cycle
        slv_ack_en = 1'b0;
        cmd_we     = 1'b0;
        cmd_adr    = 32'h3085_0000;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_cyc_before", 64'(wbm_cyc), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 64'(wbm_cyc), 64'd0);
        chk("mid_rst_stb", 64'(wbm_stb), 64'd0);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", 64'(cmd_ready), 64'd1);
        slv_ack_en = 1'b1;
        slv_wait   = 2;
        send(1'b1, 32'h3086_000C, 32'h1234_5678, 4'hC, '{32'h0, 1'b0, 1'b0});
        drain();

        // Back-to-back random traffic with cmd_valid held high
        slv_rand  = 1'b1;
        rsp_ready = 1'b1;
        base      = rsp_seen;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_we  = 1'($urandom_range(0, 1));
            cmd_adr = $urandom & 32'hFFFF_FFFC;
            cmd_dat = $urandom;
            cmd_sel = 4'($urandom_range(1, 15));
            ok      = 1'b0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("b2b_accept", 64'(ok), 64'd1);
            if (ok) exp_q.push_back('{cmd_we ? 32'h0 : model_rd(cmd_adr), 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        drain();
        chk("b2b_count", 64'(rsp_seen - base), 64'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
